// File: rtl/frequency_rate_controller_pkg.sv
// Shared definitions for the frequency rate controller: rate codes, default
// divider terminal counts and the controller FSM encoding.
package frequency_rate_controller_pkg;

    localparam int DEFAULT_CNT_W = 29;

    localparam logic [28:0] DEFAULT_DIV0 = 29'd25_000_000;
    localparam logic [28:0] DEFAULT_DIV1 = 29'd50_000_000;
    localparam logic [28:0] DEFAULT_DIV2 = 29'd100_000_000;
    localparam logic [28:0] DEFAULT_DIV3 = 29'd300_000_000;

    typedef enum logic [1:0] {
        RATE_0 = 2'd0,
        RATE_1 = 2'd1,
        RATE_2 = 2'd2,
        RATE_3 = 2'd3
    } rate_sel_t;

    typedef enum logic [1:0] {
        MANUAL_IDLE = 2'd0,
        MANUAL_PEND = 2'd1,
        SWEEP       = 2'd2
    } ctrl_state_t;

    // Sweep order is simply ascending with wrap from rate 3 back to rate 0.
    function automatic logic [1:0] next_rate(input logic [1:0] sel);
        return sel + 2'd1;
    endfunction

endpackage

// File: rtl/frequency_rate_controller_counter.sv
// Free-running period counter: counts 0..term, flags the boundary cycle and
// emits a registered one-cycle tick at the start of each new period.
module rate_period_counter #(
    parameter int CNT_W = 29
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             boundary,
    output logic             tick
);

    assign boundary = (count == term);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (boundary) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/frequency_rate_controller.sv
// Rate sequencer for the slow tick: accepts manual rate requests and applies
// them only at period boundaries, or sweeps through the four rates.
module frequency_rate_controller
    import frequency_rate_controller_pkg::*;
#(
    parameter int               CNT_W       = DEFAULT_CNT_W,
    parameter logic [CNT_W-1:0] DIV0        = CNT_W'(DEFAULT_DIV0),
    parameter logic [CNT_W-1:0] DIV1        = CNT_W'(DEFAULT_DIV1),
    parameter logic [CNT_W-1:0] DIV2        = CNT_W'(DEFAULT_DIV2),
    parameter logic [CNT_W-1:0] DIV3        = CNT_W'(DEFAULT_DIV3),
    parameter int               SWEEP_TICKS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mode,
    input  logic             req_valid,
    input  logic [1:0]       req_sel,
    output logic             req_ready,
    output logic             tick,
    output logic [1:0]       cur_sel,
    output logic             pending,
    output logic [CNT_W-1:0] count
);

    localparam int TC_W = (SWEEP_TICKS > 1) ? $clog2(SWEEP_TICKS) : 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(SWEEP_TICKS - 1);

    ctrl_state_t      state;
    ctrl_state_t      next_state;
    logic [1:0]       pend_sel;
    logic [TC_W-1:0]  tick_cnt;
    logic [CNT_W-1:0] term;
    logic             boundary;
    logic             accept;
    logic             apply_pend;
    logic             sweep_step;
    logic             sweep_wrap;
    logic             enter_sweep;

    always_comb begin
        term = DIV0;
        case (cur_sel)
            RATE_0:  term = DIV0;
            RATE_1:  term = DIV1;
            RATE_2:  term = DIV2;
            RATE_3:  term = DIV3;
            default: term = DIV0;
        endcase
    end

    rate_period_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clock   (clock),
        .reset   (reset),
        .term    (term),
        .count   (count),
        .boundary(boundary),
        .tick    (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= MANUAL_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        apply_pend = 1'b0;
        sweep_step = 1'b0;
        case (state)
            MANUAL_IDLE: begin
                req_ready = !mode;
                accept    = req_valid && !mode;
                if (mode) begin
                    next_state = SWEEP;
                end else if (accept) begin
                    next_state = MANUAL_PEND;
                end
            end
            MANUAL_PEND: begin
                // The held rate wins over sweep stepping at this boundary.
                if (boundary) begin
                    apply_pend = 1'b1;
                    next_state = mode ? SWEEP : MANUAL_IDLE;
                end
            end
            SWEEP: begin
                sweep_step = boundary;
                if (!mode) begin
                    next_state = MANUAL_IDLE;
                end
            end
            default: next_state = MANUAL_IDLE;
        endcase
    end

    assign sweep_wrap  = sweep_step && (tick_cnt == TC_LAST);
    assign enter_sweep = (state != SWEEP) && (next_state == SWEEP);
    assign pending     = (state == MANUAL_PEND);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_sel <= RATE_0;
            cur_sel  <= RATE_0;
            tick_cnt <= '0;
        end else begin
            if (accept) begin
                pend_sel <= req_sel;
            end
            if (apply_pend) begin
                cur_sel <= pend_sel;
            end else if (sweep_wrap) begin
                cur_sel <= next_rate(cur_sel);
            end
            if (enter_sweep || sweep_wrap) begin
                tick_cnt <= '0;
            end else if (sweep_step) begin
                tick_cnt <= tick_cnt + TC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frequency_rate_controller.sv
// Directed bench for frequency_rate_controller with small dividers (3/5/7/9)
// and two ticks per sweep step.
module tb_frequency_rate_controller;

    logic        clock;
    logic        reset;
    logic        mode;
    logic        req_valid;
    logic [1:0]  req_sel;
    logic        req_ready;
    logic        tick;
    logic [1:0]  cur_sel;
    logic        pending;
    logic [28:0] count;

    int tests_run    = 0;
    int tests_failed = 0;

    frequency_rate_controller #(
        .CNT_W      (29),
        .DIV0       (29'd3),
        .DIV1       (29'd5),
        .DIV2       (29'd7),
        .DIV3       (29'd9),
        .SWEEP_TICKS(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .mode     (mode),
        .req_valid(req_valid),
        .req_sel  (req_sel),
        .req_ready(req_ready),
        .tick     (tick),
        .cur_sel  (cur_sel),
        .pending  (pending),
        .count    (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Returns on the negedge where count is 0 again after reset release.
    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        req_sel   = 2'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Cycles until the next tick is seen; -1 if it never arrives.
    task automatic wait_tick(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (tick === 1'b1) begin
                cycles = i;
                return;
            end
        end
        cycles = -1;
    endtask

    task automatic test_reset();
        mode      = 1'b0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_sel   = 2'd0;
        #1;
        tests_run++;
        if (count !== 29'd0 || tick !== 1'b0 || cur_sel !== 2'd0 || pending !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: count=%0d tick=%b cur_sel=%0d pending=%b, want 0/0/0/0",
                     count, tick, cur_sel, pending);
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b want 1", req_ready);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        int exp_cnt;
        int gap;
        do_reset();
        tests_run++;
        if (count !== 29'd0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL free_start: count=%0d ready=%b want 0/1", count, req_ready);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            exp_cnt = (k + 1) % 4;
            tests_run++;
            if (count !== 29'(exp_cnt) || tick !== (exp_cnt == 0)) begin
                tests_failed++;
                $display("[TB] FAIL free_count[%0d]: count=%0d tick=%b want %0d/%b",
                         k, count, tick, exp_cnt, exp_cnt == 0);
            end
        end
        wait_tick(gap);
        tests_run++;
        if (gap !== 4 || cur_sel !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL free_spacing: gap=%0d cur_sel=%0d want 4/0", gap, cur_sel);
        end
    endtask

    task automatic test_manual_switch();
        int gap;
        do_reset();
        @(negedge clock);
        req_valid = 1'b1;
        req_sel   = 2'd2;
        @(negedge clock);
        tests_run++;
        if (pending !== 1'b1 || req_ready !== 1'b0 || count !== 29'd2) begin
            tests_failed++;
            $display("[TB] FAIL switch_accept: pending=%b ready=%b count=%0d want 1/0/2",
                     pending, req_ready, count);
        end
        req_sel = 2'd3;
        @(negedge clock);
        tests_run++;
        if (pending !== 1'b1 || cur_sel !== 2'd0 || count !== 29'd3) begin
            tests_failed++;
            $display("[TB] FAIL switch_hold: pending=%b cur_sel=%0d count=%0d want 1/0/3",
                     pending, cur_sel, count);
        end
        req_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (cur_sel !== 2'd2 || pending !== 1'b0 || tick !== 1'b1 || count !== 29'd0) begin
            tests_failed++;
            $display("[TB] FAIL switch_apply: cur_sel=%0d pending=%b tick=%b count=%0d want 2/0/1/0",
                     cur_sel, pending, tick, count);
        end
        wait_tick(gap);
        tests_run++;
        if (gap !== 8 || cur_sel !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL switch_spacing: gap=%0d cur_sel=%0d want 8/2", gap, cur_sel);
        end
    endtask

    task automatic test_boundary_request();
        int gap;
        do_reset();
        repeat (3) @(negedge clock);
        req_valid = 1'b1;
        req_sel   = 2'd1;
        @(negedge clock);
        req_valid = 1'b0;
        tests_run++;
        if (tick !== 1'b1 || pending !== 1'b1 || cur_sel !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL bnd_accept: tick=%b pending=%b cur_sel=%0d want 1/1/0",
                     tick, pending, cur_sel);
        end
        wait_tick(gap);
        tests_run++;
        if (gap !== 4 || cur_sel !== 2'd1 || pending !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bnd_old_period: gap=%0d cur_sel=%0d pending=%b want 4/1/0",
                     gap, cur_sel, pending);
        end
        for (int i = 0; i < 2; i++) begin
            wait_tick(gap);
            tests_run++;
            if (gap !== 6) begin
                tests_failed++;
                $display("[TB] FAIL bnd_new_period[%0d]: gap=%0d want 6", i, gap);
            end
        end
    endtask

    task automatic test_sweep();
        int gap;
        int exp_gap[9] = '{4, 4, 6, 6, 8, 8, 10, 10, 4};
        int exp_sel[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        mode = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tests_run++;
            if (cur_sel !== 2'(exp_sel[i]) || req_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL sweep_sel[%0d]: cur_sel=%0d ready=%b want %0d/0",
                         i, cur_sel, req_ready, exp_sel[i]);
            end
            wait_tick(gap);
            tests_run++;
            if (gap !== exp_gap[i]) begin
                tests_failed++;
                $display("[TB] FAIL sweep_gap[%0d]: gap=%0d want %0d", i, gap, exp_gap[i]);
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_pend_then_sweep();
        int gap;
        mode = 1'b0;
        do_reset();
        @(negedge clock);
        req_valid = 1'b1;
        req_sel   = 2'd3;
        @(negedge clock);
        req_valid = 1'b0;
        mode      = 1'b1;
        tests_run++;
        if (pending !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL ps_pending: got %b want 1", pending);
        end
        repeat (2) @(negedge clock);
        tests_run++;
        if (cur_sel !== 2'd3 || pending !== 1'b0 || tick !== 1'b1 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL ps_apply: cur_sel=%0d pending=%b tick=%b ready=%b want 3/0/1/0",
                     cur_sel, pending, tick, req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            wait_tick(gap);
            tests_run++;
            if (gap !== 10) begin
                tests_failed++;
                $display("[TB] FAIL ps_gap[%0d]: gap=%0d want 10", i, gap);
            end
        end
        tests_run++;
        if (cur_sel !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL ps_advance: cur_sel=%0d want 0", cur_sel);
        end
        wait_tick(gap);
        tests_run++;
        if (gap !== 4) begin
            tests_failed++;
            $display("[TB] FAIL ps_wrap_gap: gap=%0d want 4", gap);
        end
        mode = 1'b0;
    endtask

    task automatic test_reset_mid_period();
        int gap;
        mode = 1'b0;
        do_reset();
        @(negedge clock);
        req_valid = 1'b1;
        req_sel   = 2'd1;
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        tests_run++;
        if (cur_sel !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL rst_setup: cur_sel=%0d want 1", cur_sel);
        end
        @(negedge clock);
        req_valid = 1'b1;
        req_sel   = 2'd2;
        @(negedge clock);
        req_valid = 1'b0;
        tests_run++;
        if (pending !== 1'b1 || count !== 29'd2) begin
            tests_failed++;
            $display("[TB] FAIL rst_pre: pending=%b count=%0d want 1/2", pending, count);
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (count !== 29'd0 || tick !== 1'b0 || cur_sel !== 2'd0 || pending !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_async: count=%0d tick=%b cur_sel=%0d pending=%b want 0/0/0/0",
                     count, tick, cur_sel, pending);
        end
        @(negedge clock);
        reset = 1'b0;
        wait_tick(gap);
        tests_run++;
        if (gap !== 4 || cur_sel !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL rst_first_tick: gap=%0d cur_sel=%0d want 4/0", gap, cur_sel);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_manual_switch();
        test_boundary_request();
        test_sweep();
        test_pend_then_sweep();
        test_reset_mid_period();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
